// File: rtl/mux_select_arbiter_pkg.sv
// Shared encodings for the mux_select_arbiter front end: FSM states and
// the mux select values driven on S.
package mux_select_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_A = 2'd1,
    SERVE_B = 2'd2
  } state_t;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

endpackage

// File: rtl/mux_select_arbiter_burst_counter.sv
// Saturating burst counter: counts accepted words of the current burst and
// flags when the burst limit has been reached.
module burst_counter #(
  parameter int MAX = 4
) (
  input  logic Clk,
  input  logic Rst,
  input  logic clear,
  input  logic inc,
  output logic atMax
);

  localparam int CW = $clog2(MAX + 1);
  localparam logic [CW-1:0] MAXV = CW'(MAX);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic [CW-1:0] count;

  assign atMax = (count == MAXV);

  // A clear that coincides with an accepted word starts the new burst at one,
  // so the word granted on a switch cycle counts toward the new source's burst.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      count <= '0;
    end else if (clear) begin
      count <= inc ? ONE : '0;
    end else if (inc && !atMax) begin
      count <= count + ONE;
    end
  end

endmodule

// File: rtl/mux_select_arbiter.sv
// Round-robin arbiter for two valid/ready sources with bounded bursts; drives
// the mux select and registers the winning word into a one-entry output slot.
module mux_select_arbiter
  import mux_select_arbiter_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int BURST = 4
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             ValidA,
  input  logic [WIDTH-1:0] DataA,
  output logic             ReadyA,
  input  logic             ValidB,
  input  logic [WIDTH-1:0] DataB,
  output logic             ReadyB,
  output logic             S,
  output logic             OutValid,
  output logic [WIDTH-1:0] OutData,
  input  logic             OutReady
);

  state_t state;
  state_t nextState;
  logic   granted;
  logic   slotFree;
  logic   grantA;
  logic   grantB;
  logic   cntClear;
  logic   atMax;

  assign slotFree = !OutValid || OutReady;

  // Candidate grant for this cycle; it only takes effect when the slot is free.
  // In IDLE a tie goes to A until the first grant, then to the source not last granted.
  always_comb begin
    grantA    = 1'b0;
    grantB    = 1'b0;
    cntClear  = 1'b0;
    nextState = state;
    case (state)
      IDLE: begin
        cntClear = 1'b1;
        if (ValidA && ValidB) begin
          if (!granted || S == SEL_B) grantA = 1'b1;
          else                        grantB = 1'b1;
        end else begin
          grantA = ValidA;
          grantB = ValidB;
        end
      end
      SERVE_A: begin
        if (ValidB && (!ValidA || atMax)) begin
          grantB   = 1'b1;
          cntClear = 1'b1;
        end else begin
          grantA = ValidA;
        end
      end
      SERVE_B: begin
        if (ValidA && (!ValidB || atMax)) begin
          grantA   = 1'b1;
          cntClear = 1'b1;
        end else begin
          grantB = ValidB;
        end
      end
      default: cntClear = 1'b1;
    endcase
    if (grantA)      nextState = SERVE_A;
    else if (grantB) nextState = SERVE_B;
    else begin
      nextState = IDLE;
      cntClear  = 1'b1;
    end
  end

  assign ReadyA = grantA && slotFree && !Rst;
  assign ReadyB = grantB && slotFree && !Rst;

  burst_counter #(
    .MAX(BURST)
  ) u_burst (
    .Clk  (Clk),
    .Rst  (Rst),
    .clear(cntClear && slotFree),
    .inc  ((grantA || grantB) && slotFree),
    .atMax(atMax)
  );

  // With a full, stalled slot everything freezes; otherwise the slot drains
  // and, if a word was accepted, refills in the same cycle.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state    <= IDLE;
      S        <= SEL_A;
      OutValid <= 1'b0;
      OutData  <= '0;
      granted  <= 1'b0;
    end else if (slotFree) begin
      state <= nextState;
      if (grantA || grantB) begin
        OutValid <= 1'b1;
        OutData  <= grantB ? DataB : DataA;
        S        <= grantB ? SEL_B : SEL_A;
        granted  <= 1'b1;
      end else begin
        OutValid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mux_select_arbiter.sv
// Directed bench for mux_select_arbiter: a vector table for grant order and
// bursts, hand sequences for stall and reset, and an in-order scoreboard.
module tb_mux_select_arbiter;

  logic       Clk = 1'b0;
  logic       Rst = 1'b1;
  logic       ValidA = 1'b0;
  logic [7:0] DataA = '0;
  logic       ReadyA;
  logic       ValidB = 1'b0;
  logic [7:0] DataB = '0;
  logic       ReadyB;
  logic       S;
  logic       OutValid;
  logic [7:0] OutData;
  logic       OutReady = 1'b0;

  int checkCount = 0;
  int passCount  = 0;
  logic [7:0] expQ[$];

  typedef struct {
    logic       va;
    logic [7:0] da;
    logic       vb;
    logic [7:0] db;
    logic       ordy;
    logic       ra;
    logic       rb;
    logic       s;
    logic       ov;
    logic [7:0] od;
  } vec_t;

  vec_t vecs[$];

  mux_select_arbiter #(.WIDTH(8), .BURST(4)) dut (
    .Clk     (Clk),
    .Rst     (Rst),
    .ValidA  (ValidA),
    .DataA   (DataA),
    .ReadyA  (ReadyA),
    .ValidB  (ValidB),
    .DataB   (DataB),
    .ReadyB  (ReadyB),
    .S       (S),
    .OutValid(OutValid),
    .OutData (OutData),
    .OutReady(OutReady)
  );

  always #5 Clk = ~Clk;

  task automatic checkVal(input string name, input logic [7:0] act, input logic [7:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
  endtask

  // Scoreboard: words leave the slot exactly once and in acceptance order.
  always @(posedge Clk) begin
    if (Rst) begin
      expQ.delete();
    end else begin
      checkCount++;
      if (!(ReadyA && ReadyB) && !(ReadyA && !ValidA) && !(ReadyB && !ValidB)) passCount++;
      else $display("[TB] FAIL readyProtocol actual=%b%b required=at most one valid ready at %0t",
                    ReadyA, ReadyB, $time);
      if (OutValid && OutReady) begin
        if (expQ.size() == 0) begin
          checkCount++;
          $display("[TB] FAIL orderEmpty actual=%h required=no output at %0t", OutData, $time);
        end else begin
          checkVal("orderData", OutData, expQ.pop_front());
        end
      end
      if (ValidA && ReadyA) expQ.push_back(DataA);
      if (ValidB && ReadyB) expQ.push_back(DataB);
    end
  end

  task automatic addVec(input logic va, input logic [7:0] da, input logic vb, input logic [7:0] db,
                        input logic ordy, input logic ra, input logic rb,
                        input logic s, input logic ov, input logic [7:0] od);
    vec_t v;
    v.va = va; v.da = da; v.vb = vb; v.db = db; v.ordy = ordy;
    v.ra = ra; v.rb = rb; v.s = s; v.ov = ov; v.od = od;
    vecs.push_back(v);
  endtask

  task automatic applyStimulus(input logic va, input logic [7:0] da, input logic vb,
                               input logic [7:0] db, input logic ordy);
    ValidA = va; DataA = da; ValidB = vb; DataB = db; OutReady = ordy;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic s, input logic ov, input logic [7:0] od);
    checkVal({tag, ".S"}, {7'd0, S}, {7'd0, s});
    checkVal({tag, ".OutValid"}, {7'd0, OutValid}, {7'd0, ov});
    checkVal({tag, ".OutData"}, OutData, od);
  endtask

  task automatic checkReady(input string tag, input logic ra, input logic rb);
    checkVal({tag, ".ReadyA"}, {7'd0, ReadyA}, {7'd0, ra});
    checkVal({tag, ".ReadyB"}, {7'd0, ReadyB}, {7'd0, rb});
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Ties after reset, single-source transfer, continuous tie bursts,
    // late-arriving B and saturation while B is idle.
    addVec(1, 8'hA1, 1, 8'hB1, 1, 1, 0, 0, 1, 8'hA1);
    addVec(0, 8'h00, 0, 8'h00, 1, 0, 0, 0, 0, 8'hA1);
    addVec(1, 8'hA2, 1, 8'hB2, 1, 0, 1, 1, 1, 8'hB2);
    addVec(0, 8'h00, 0, 8'h00, 1, 0, 0, 1, 0, 8'hB2);
    addVec(1, 8'hA3, 1, 8'hB3, 1, 1, 0, 0, 1, 8'hA3);
    addVec(0, 8'h00, 0, 8'h00, 1, 0, 0, 0, 0, 8'hA3);
    addVec(1, 8'h3C, 0, 8'h00, 1, 1, 0, 0, 1, 8'h3C);
    addVec(0, 8'h00, 0, 8'h00, 1, 0, 0, 0, 0, 8'h3C);
    for (int i = 0; i < 9; i++) begin
      logic gb;
      gb = (i < 4) || (i == 8);
      addVec(1, 8'h10 + 8'(i), 1, 8'h20 + 8'(i), 1, !gb, gb, gb, 1,
             gb ? 8'h20 + 8'(i) : 8'h10 + 8'(i));
    end
    addVec(0, 8'h00, 0, 8'h00, 1, 0, 0, 1, 0, 8'h28);
    addVec(1, 8'h40, 0, 8'h00, 1, 1, 0, 0, 1, 8'h40);
    addVec(1, 8'h41, 0, 8'h00, 1, 1, 0, 0, 1, 8'h41);
    addVec(1, 8'h42, 1, 8'h50, 1, 1, 0, 0, 1, 8'h42);
    addVec(1, 8'h43, 1, 8'h50, 1, 1, 0, 0, 1, 8'h43);
    addVec(1, 8'h44, 1, 8'h50, 1, 0, 1, 1, 1, 8'h50);
    addVec(1, 8'h44, 0, 8'h00, 1, 1, 0, 0, 1, 8'h44);
    for (int i = 0; i < 4; i++)
      addVec(1, 8'h45 + 8'(i), 0, 8'h00, 1, 1, 0, 0, 1, 8'h45 + 8'(i));
    addVec(1, 8'h49, 1, 8'h51, 1, 0, 1, 1, 1, 8'h51);
    addVec(0, 8'h00, 0, 8'h00, 1, 0, 0, 1, 0, 8'h51);

    Rst = 1'b1;
    #1;
    checkReady("reset", 0, 0);
    checkOutput("reset", 0, 0, 8'h00);
    step();
    Rst = 1'b0;
    #1;

    foreach (vecs[i]) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      applyStimulus(vecs[i].va, vecs[i].da, vecs[i].vb, vecs[i].db, vecs[i].ordy);
      checkReady(tag, vecs[i].ra, vecs[i].rb);
      step();
      checkOutput(tag, vecs[i].s, vecs[i].ov, vecs[i].od);
    end

    // Stall: slot full with downstream blocked, then drain and refill together.
    applyStimulus(1, 8'h60, 0, 8'h00, 0);
    checkReady("stallFill", 1, 0);
    step();
    checkOutput("stallFill", 0, 1, 8'h60);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1, 8'h61, 1, 8'h70, 0);
      checkReady($sformatf("stall%0d", i), 0, 0);
      step();
      checkOutput($sformatf("stall%0d", i), 0, 1, 8'h60);
    end
    applyStimulus(1, 8'h61, 1, 8'h70, 1);
    checkReady("stallDrain", 1, 0);
    step();
    checkOutput("stallDrain", 0, 1, 8'h61);
    applyStimulus(0, 8'h00, 0, 8'h00, 1);
    step();
    checkOutput("stallEmpty", 0, 0, 8'h61);

    // Reset while the slot holds a B word must clear everything immediately.
    applyStimulus(0, 8'h00, 1, 8'h81, 0);
    checkReady("preReset", 0, 1);
    step();
    checkOutput("preReset", 1, 1, 8'h81);
    applyStimulus(1, 8'h90, 1, 8'h91, 0);
    Rst = 1'b1;
    #1;
    checkReady("midReset", 0, 0);
    checkOutput("midReset", 0, 0, 8'h00);
    step();
    Rst = 1'b0;
    #1;
    checkReady("postResetTie", 1, 0);
    step();
    checkOutput("postResetTie", 0, 1, 8'h90);
    applyStimulus(0, 8'h00, 0, 8'h00, 1);
    step();
    checkOutput("final", 0, 0, 8'h90);
    step();
    checkVal("queueEmpty", 8'(expQ.size()), 8'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
